quantum_rr_arbiter: RTL

QUANTUM_RR_ARBITER -- requirements
Module: quantum_rr_arbiter

---
 rtl/quantum_rr_arbiter_pkg.sv | 5 +
 rtl/quantum_rr_arbiter_if.sv | 12 +
 rtl/quantum_rr_arbiter_rr_pick.sv | 18 +
 rtl/quantum_rr_arbiter.sv | 56 +++++
 4 files changed

// File: rtl/quantum_rr_arbiter_pkg.sv
// qrr_pkg: shared state encoding and counter width for quantum_rr_arbiter
package qrr_pkg;
  typedef enum logic {QRR_IDLE, QRR_SERVE} qrr_state_t;
  localparam int CNT_WIDTH = 16;
endpackage

// File: rtl/quantum_rr_arbiter_if.sv
// quantum_rr_arbiter_if: request/quantum inputs and grant/status outputs of the arbiter
interface quantum_rr_arbiter_if #(parameter int NUM_REQS = 2, parameter int QWID = 3);
  import qrr_pkg::*;
  logic [NUM_REQS-1:0] reqs;
  logic [NUM_REQS*QWID-1:0] quantums;
  logic [NUM_REQS-1:0] gnt;
  logic [$clog2(NUM_REQS)-1:0] owner;
  logic busy;
  logic [CNT_WIDTH-1:0] gnt_cnt;
  modport master(output reqs, quantums, input gnt, owner, busy, gnt_cnt);
  modport slave(input reqs, quantums, output gnt, owner, busy, gnt_cnt);
endinterface

// File: rtl/quantum_rr_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder, first set request after start, wrapping back to start
module rr_pick #(parameter int N = 2, localparam int IW = $clog2(N)) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] pick,
  output logic          valid
);
  logic [IW-1:0] idx;
  always_comb begin
    pick = '0;
    idx = '0;
    valid = |reqs;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(start) + k) % N);
      if (reqs[idx]) pick = idx;
    end
  end
endmodule

// File: rtl/quantum_rr_arbiter.sv
// quantum_rr_arbiter: round-robin arbiter granting each owner up to its quantum of consecutive pops
// Optional grant counter enabled by defining QRR_GNT_CNT_EN.
module quantum_rr_arbiter import qrr_pkg::*; #(
  parameter int NUM_REQS = 2,
  parameter int QWID = 3
) (
  input logic clk,
  input logic rst,
  quantum_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQS);
  qrr_state_t state, state_nx;
  logic [IW-1:0] owner, pick;
  logic [QWID-1:0] credit, q_sel, eff_q;
  logic [NUM_REQS-1:0] gnt;
  logic valid, grant_own;
  rr_pick #(.N(NUM_REQS)) u_pick (.reqs(bus.reqs), .start(owner), .pick(pick), .valid(valid));
  assign q_sel = bus.quantums[int'(pick)*QWID +: QWID];
  assign eff_q = q_sel == '0 ? QWID'(1) : q_sel;
  assign grant_own = state == QRR_SERVE && bus.reqs[owner];
  always_comb begin
    gnt = '0;
    if (rst && grant_own) gnt[owner] = 1'b1;
    else if (rst && valid) gnt[pick] = 1'b1;
    state_nx = grant_own ? (credit == QWID'(1) ? QRR_IDLE : QRR_SERVE)
             : (valid && eff_q != QWID'(1)) ? QRR_SERVE : QRR_IDLE;
  end
  // a dropped owner falls through to a fresh load, discarding its leftover credit
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= QRR_IDLE;
      owner <= IW'(NUM_REQS - 1);
      credit <= '0;
    end else begin
      state <= state_nx;
      if (grant_own) credit <= credit - 1'b1;
      else if (valid) begin
        owner <= pick;
        credit <= eff_q - 1'b1;
      end
    end
  end
  assign bus.gnt = gnt;
  assign bus.owner = owner;
  assign bus.busy = state == QRR_SERVE;
`ifdef QRR_GNT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (|gnt && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign bus.gnt_cnt = cnt;
`else
  assign bus.gnt_cnt = '0;
`endif
endmodule
